// File: rtl/data_mem_mmio.sv
// Data-side memory stage: word RAM plus an MMIO page holding a compare timer
// with interrupt and an 8-bit LED register. Loads are combinational, stores land on the edge.
module data_mem_mmio #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic        irq,
    output logic [7:0]  leds
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [2:0]    ctrl_q, ctrl_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   cmp_q, cmp_d;
    logic          match_q, match_d;
    logic [7:0]    led_q, led_d;
    logic          irq_q, irq_d;

    logic          ram_hit_s, mmio_hit_s, mmio_wr_s, match_evt_s;
    logic [AW-1:0] ram_idx_s;
    logic [5:0]    reg_off_s;
    logic [31:0]   rdata_s;
    logic          unused_addr_s;

    // Byte lane bits are ignored; every access is a whole word.
    assign unused_addr_s = ^Mem_WrAddr[1:0];
    assign ram_hit_s     = (Mem_WrAddr[31:AW+2] == {(30-AW){1'b0}});
    assign mmio_hit_s    = (Mem_WrAddr[31:8] == MMIO_BASE[31:8]);
    assign ram_idx_s     = Mem_WrAddr[AW+1:2];
    assign reg_off_s     = Mem_WrAddr[7:2];
    assign mmio_wr_s     = MemWrite && mmio_hit_s && !ram_hit_s;
    assign match_evt_s   = ctrl_q[0] && (count_q == cmp_q);

    // Load mux: RAM, MMIO register, or zero for unmapped addresses.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (ram_hit_s) begin
            rdata_s = mem_q[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (reg_off_s)
                6'h00:   rdata_s = {29'h0000_0000, ctrl_q};
                6'h01:   rdata_s = count_q;
                6'h02:   rdata_s = cmp_q;
                6'h03:   rdata_s = {31'h0000_0000, match_q};
                6'h04:   rdata_s = {24'h00_0000, led_q};
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign ReadData = rdata_s;

    // RAM store; contents survive reset, but a store in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset && MemWrite && ram_hit_s) begin
            mem_q[ram_idx_s] <= Mem_WrData;
        end
    end

    // Timer advance, then register stores; stores override the timer, a new match overrides W1C.
    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        cmp_d   = cmp_q;
        match_d = match_q;
        led_d   = led_q;
        if (ctrl_q[0]) begin
            if (match_evt_s && ctrl_q[1]) begin
                count_d = 32'h0000_0000;
            end else begin
                count_d = count_q + 32'd1;
            end
        end else begin
            count_d = count_q;
        end
        if (mmio_wr_s) begin
            case (reg_off_s)
                6'h00:   ctrl_d  = Mem_WrData[2:0];
                6'h01:   count_d = Mem_WrData;
                6'h02:   cmp_d   = Mem_WrData;
                6'h03:   match_d = match_q & ~Mem_WrData[0];
                6'h04:   led_d   = Mem_WrData[7:0];
                default: ctrl_d  = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
        if (match_evt_s) begin
            match_d = 1'b1;
        end else begin
            match_d = match_d;
        end
        irq_d = match_d & ctrl_d[2];
    end

    // MMIO state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= 3'b000;
            count_q <= 32'h0000_0000;
            cmp_q   <= 32'hFFFF_FFFF;
            match_q <= 1'b0;
            led_q   <= 8'h00;
            irq_q   <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            led_q   <= led_d;
            irq_q   <= irq_d;
        end
    end

    assign irq  = irq_q;
    assign leds = led_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed bench for data_mem_mmio: expectations queued as stimulus is driven,
// popped and checked with immediate assertions when the outputs are sampled.
module tb_data_mem_mmio;

    localparam logic [31:0] M = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [31:0] ReadData;
    logic        irq;
    logic [7:0]  leds;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    data_mem_mmio #(.DEPTH_WORDS(64), .MMIO_BASE(M)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr),
        .Mem_WrData(Mem_WrData), .ReadData(ReadData), .irq(irq), .leds(leds)
    );

    always #50 clk = ~clk;

    task automatic compare(input logic [31:0] obs, input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // one clock edge with the given bus inputs; starts and ends just after a falling edge
    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite   = we;
        Mem_WrAddr = a;
        Mem_WrData = d;
        @(negedge clk);
        MemWrite   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string tag);
        MemWrite   = 1'b0;
        Mem_WrAddr = a;
        exp_q.push_back(e);
        #1;
        compare(ReadData, tag);
    endtask

    task automatic chk_irq(input logic e, input string tag);
        exp_q.push_back({31'h0000_0000, e});
        #1;
        compare({31'h0000_0000, irq}, tag);
    endtask

    task automatic chk_leds(input logic [7:0] e, input string tag);
        exp_q.push_back({24'h00_0000, e});
        #1;
        compare({24'h00_0000, leds}, tag);
    endtask

    initial begin
        reset = 1'b0; MemWrite = 1'b0; Mem_WrAddr = 32'h0; Mem_WrData = 32'h0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        rd(M + 32'h00, 32'h0000_0000, "rst_ctrl");
        rd(M + 32'h04, 32'h0000_0000, "rst_count");
        rd(M + 32'h08, 32'hFFFF_FFFF, "rst_cmp");
        rd(M + 32'h0C, 32'h0000_0000, "rst_status");
        chk_irq(1'b0, "rst_irq");
        chk_leds(8'h00, "rst_leds");

        // RAM basics and read-during-write
        step(1'b1, 32'h0000_0000, 32'hA0A0_A0A0);
        step(1'b1, 32'h0000_0014, 32'h1111_1111);
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        rd(32'h0000_0010, 32'hDEAD_BEEF, "ram_10");
        rd(32'h0000_0013, 32'hDEAD_BEEF, "ram_13");
        rd(32'h0000_0014, 32'h1111_1111, "ram_14_kept");
        MemWrite = 1'b1; Mem_WrAddr = 32'h0000_0010; Mem_WrData = 32'h55AA_55AA;
        exp_q.push_back(32'hDEAD_BEEF);
        #1;
        compare(ReadData, "rdw_old");
        @(negedge clk);
        MemWrite = 1'b0;
        rd(32'h0000_0010, 32'h55AA_55AA, "rdw_new");

        // unmapped store, LED register, unused offset
        step(1'b1, 32'h0000_0800, 32'h1234_5678);
        rd(32'h0000_0800, 32'h0000_0000, "unmapped_rd");
        rd(32'h0000_0000, 32'hA0A0_A0A0, "unmapped_no_alias");
        chk_leds(8'h00, "unmapped_leds");
        step(1'b1, M + 32'h10, 32'h0000_01A5);
        chk_leds(8'hA5, "led_out");
        rd(M + 32'h10, 32'h0000_00A5, "led_rd");
        rd(M + 32'h14, 32'h0000_0000, "unused_off");

        // auto-reload timer with irq
        step(1'b1, M + 32'h08, 32'd5);
        step(1'b1, M + 32'h00, 32'hFFFF_FFF7);
        rd(M + 32'h00, 32'h0000_0007, "ctrl_mask");
        rd(M + 32'h04, 32'h0000_0000, "count_start");
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 32'h0, 32'h0);
            rd(M + 32'h04, i, "count_seq");
        end
        rd(M + 32'h0C, 32'h0000_0000, "no_match_yet");
        chk_irq(1'b0, "no_irq_yet");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h04, 32'h0000_0000, "auto_reload");
        rd(M + 32'h0C, 32'h0000_0001, "match_set");
        chk_irq(1'b1, "irq_set");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h04, 32'h0000_0001, "count_after_reload");
        step(1'b1, M + 32'h0C, 32'h0000_0001);
        rd(M + 32'h0C, 32'h0000_0000, "w1c_clear");
        chk_irq(1'b0, "irq_clear");
        rd(M + 32'h04, 32'h0000_0002, "count_during_w1c");

        // free-run wrap and store-wins
        step(1'b1, M + 32'h00, 32'h0000_0005);
        step(1'b1, M + 32'h04, 32'hFFFF_FFFE);
        rd(M + 32'h04, 32'hFFFF_FFFE, "count_store_wins");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h04, 32'hFFFF_FFFF, "count_ffff");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h04, 32'h0000_0000, "count_wrap");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h04, 32'h0000_0001, "count_after_wrap");
        step(1'b1, M + 32'h04, 32'd100);
        rd(M + 32'h04, 32'd100, "count_store_100");

        // new match on the same edge as a W1C clear
        step(1'b1, M + 32'h08, 32'd102);
        rd(M + 32'h08, 32'd102, "cmp_rd");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h0C, 32'h0000_0000, "pre_match");
        step(1'b0, 32'h0, 32'h0);
        rd(M + 32'h0C, 32'h0000_0001, "match_noauto");
        rd(M + 32'h04, 32'd103, "count_noauto");
        step(1'b1, M + 32'h08, 32'd104);
        step(1'b1, M + 32'h0C, 32'h0000_0001);
        rd(M + 32'h0C, 32'h0000_0001, "set_beats_clear");
        chk_irq(1'b1, "irq_set_beats_clear");
        step(1'b1, M + 32'h0C, 32'h0000_0001);
        rd(M + 32'h0C, 32'h0000_0000, "plain_clear");
        chk_irq(1'b0, "irq_plain_clear");

        // reset mid-run with a concurrent LED store
        step(1'b1, M + 32'h04, 32'd104);
        step(1'b0, 32'h0, 32'h0);
        chk_irq(1'b1, "irq_before_reset");
        reset = 1'b0;
        step(1'b1, M + 32'h10, 32'h0000_00FF);
        reset = 1'b1;
        chk_leds(8'h00, "reset_leds");
        chk_irq(1'b0, "reset_irq");
        rd(M + 32'h00, 32'h0000_0000, "reset_ctrl");
        rd(M + 32'h04, 32'h0000_0000, "reset_count");
        rd(M + 32'h08, 32'hFFFF_FFFF, "reset_cmp");
        rd(M + 32'h0C, 32'h0000_0000, "reset_status");
        rd(32'h0000_0014, 32'h1111_1111, "ram_keeps_14");
        rd(32'h0000_0010, 32'h55AA_55AA, "ram_keeps_10");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
